// File: rtl/melody_pkg.sv
// melody_pkg: shared definitions for the melody player.
//   - FSM state encoding
//   - ROM entry layout {dur[1:0], rest, note[3:0]} and its field offsets
//   - song length and end-of-song marker
//   - note_onehot(): note number to active-high tone select
package melody_pkg;

   localparam int SONG_LEN = 32;
   localparam int IDX_W    = 5;

   localparam int NOTE_W   = 4;
   localparam int NOTE_LSB = 0;
   localparam int REST_BIT = 4;
   localparam int DUR_W    = 2;
   localparam int DUR_LSB  = 5;
   localparam int ENTRY_W  = 7;

   localparam logic [DUR_W-1:0] DUR_END = '0;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_TONE,
      S_GAP,
      S_END
   } state_t;

   function automatic logic [15:0] note_onehot(input logic [NOTE_W-1:0] n);
      return 16'h0001 << n;
   endfunction

endpackage

// File: rtl/melody_rom.sv
// melody_rom: song storage, 32 entries of {dur, rest, note}.
//   clk  : read clock
//   addr : entry index
//   data : registered entry, valid one cycle after addr (no reset)
// Unlisted entries hold the end marker (dur = 0).
module melody_rom
   import melody_pkg::*;
(
   input  logic               clk,
   input  logic [IDX_W-1:0]   addr,
   output logic [ENTRY_W-1:0] data
);

   function automatic logic [ENTRY_W-1:0] entry(input logic [DUR_W-1:0]  dur,
                                                 input logic              rest,
                                                 input logic [NOTE_W-1:0] note);
      return {dur, rest, note};
   endfunction

   logic [ENTRY_W-1:0] word;

   always_comb begin
      word = entry(DUR_END, 1'b0, 4'd0);
      case (addr)
         5'd0:    word = entry(2'd1, 1'b0, 4'd3);
         5'd1:    word = entry(2'd2, 1'b0, 4'd5);
         5'd2:    word = entry(2'd1, 1'b1, 4'd0);
         default: ;
      endcase
   end

   always_ff @(posedge clk) data <= word;

endmodule

// File: rtl/melody_player.sv
// melody_player: plays the song in melody_rom on a one-hot beeper bus.
//   clk, rst_n : clock, async active-low reset
//   play       : start / restart pulse (song restarts at entry 0)
//   stop       : abort pulse, wins over play
//   loop_en    : restart the song instead of finishing
//   key_n      : live keypad (active-low); any key pressed overrides the
//                output and freezes playback
//   note_sel   : active-high tone select
//   busy       : FSM not idle
//   song_idx   : current ROM index
//   done       : one-cycle pulse when a non-looping song finishes
module melody_player
   import melody_pkg::*;
#(
   parameter int BEAT_CYC = 3_000_000,
   parameter int GAP_CYC  = 240_000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        play,
   input  logic        stop,
   input  logic        loop_en,
   input  logic [15:0] key_n,
   output logic [15:0] note_sel,
   output logic        busy,
   output logic [4:0]  song_idx,
   output logic        done
);

   // Counter must hold the longest tone, 3 beats.
   localparam int               CNT_W  = $clog2(3 * BEAT_CYC + 1);
   localparam logic [CNT_W-1:0] BEAT_C = CNT_W'(BEAT_CYC);
   localparam logic [CNT_W-1:0] GAP_C  = CNT_W'(GAP_CYC);

   state_t             state;
   logic [IDX_W-1:0]   idx, idx_nxt;
   logic [CNT_W-1:0]   cnt, tone_len;
   logic [ENTRY_W-1:0] rom_q;
   logic [15:0]        note_reg;
   logic               key_act;
   logic [DUR_W-1:0]   f_dur;
   logic               f_rest;
   logic [NOTE_W-1:0]  f_note;

   assign key_act  = (key_n != 16'hFFFF);
   assign f_dur    = rom_q[DUR_LSB +: DUR_W];
   assign f_rest   = rom_q[REST_BIT];
   assign f_note   = rom_q[NOTE_LSB +: NOTE_W];
   assign tone_len = CNT_W'(f_dur) * BEAT_C - GAP_C;

   // Keys bypass the register; reset silences even a held key.
   assign note_sel = (key_act && rst_n) ? ~key_n : note_reg;
   assign song_idx = idx;

   // Next index is computed ahead so the ROM word is already registered
   // by the time the FSM sits in FETCH.
   always_comb begin
      idx_nxt = idx;
      if (stop || play) begin
         idx_nxt = '0;
      end else if (!key_act) begin
         if (state == S_GAP && cnt == '0 && idx != IDX_W'(SONG_LEN - 1))
            idx_nxt = idx + 1'b1;
         if (state == S_END && loop_en)
            idx_nxt = '0;
      end
   end

   melody_rom u_rom (
      .clk  (clk),
      .addr (idx_nxt),
      .data (rom_q)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         idx      <= '0;
         cnt      <= '0;
         note_reg <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         idx  <= idx_nxt;
         if (stop) begin
            state    <= S_IDLE;
            cnt      <= '0;
            note_reg <= '0;
            busy     <= 1'b0;
         end else if (play) begin
            state    <= S_FETCH;
            cnt      <= '0;
            note_reg <= '0;
            busy     <= 1'b1;
         end else if (!key_act) begin
            // A held key freezes everything below.
            case (state)
               S_FETCH: begin
                  if (f_dur == DUR_END) begin
                     state <= S_END;
                  end else begin
                     state    <= S_TONE;
                     cnt      <= tone_len - 1'b1;
                     note_reg <= f_rest ? 16'h0000 : note_onehot(f_note);
                  end
               end
               S_TONE: begin
                  if (cnt == '0) begin
                     state    <= S_GAP;
                     cnt      <= GAP_C - 1'b1;
                     note_reg <= '0;
                  end else begin
                     cnt <= cnt - 1'b1;
                  end
               end
               S_GAP: begin
                  if (cnt == '0)
                     state <= (idx == IDX_W'(SONG_LEN - 1)) ? S_END : S_FETCH;
                  else
                     cnt <= cnt - 1'b1;
               end
               S_END: begin
                  if (loop_en) begin
                     state <= S_FETCH;
                  end else begin
                     state <= S_IDLE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule
